// File: rtl/io_pkg.sv
// Shared constants for the output-port 7-segment display driver.
//   HEX_SEG7 : active-high glyph table, bit 0 = segment a ... bit 6 = segment g
//   ST_*     : scan FSM state encoding
package io_pkg;

    localparam int unsigned SEG_W = 7;

    // Hex glyphs 0-F; b and d are lowercase so they are distinct from 8 and 0.
    localparam logic [SEG_W-1:0] HEX_SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

endpackage

// File: rtl/outport_seg7_driver_if.sv
// Port bundle between the CPU-side output port and the display driver.
//   outport_in : CPU OUTPORTout value        run    : CPU run flag
//   freeze     : hold the displayed value    seg    : segments a..g (seg[0]=a)
//   dp         : decimal point               an     : digit enables, an[0] rightmost
//   upd_pulse  : one-cycle new-value strobe
interface outport_seg7_driver_if #(
    parameter int unsigned DIGITS = 8
);
    logic [31:0]       outport_in;
    logic              run;
    logic              freeze;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;
    logic              upd_pulse;

    modport master (
        output outport_in, run, freeze,
        input  seg, dp, an, upd_pulse
    );

    modport slave (
        input  outport_in, run, freeze,
        output seg, dp, an, upd_pulse
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
//   nibble_i : 4-bit value     seg_c : segments a..g, bit 0 = a
module hex_to_seg7
    import io_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX_SEG7[nibble_i];

endmodule

// File: rtl/outport_seg7_driver.sv
// Captures the CPU output port value and scans it as hex digits onto a
// multiplexed 7-segment display, with a new-value strobe and a run
// heartbeat on digit 0's decimal point.
//   clk   : system clock (shared with CPU)
//   reset : asynchronous active-low reset
//   bus   : slave side of outport_seg7_driver_if (outport_in/run/freeze in,
//           seg/dp/an/upd_pulse out, all outputs registered)
module outport_seg7_driver
    import io_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned LEADING_BLANK  = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    outport_seg7_driver_if.slave  bus
);

    localparam int unsigned DW     = 4 * DIGITS;
    localparam int unsigned DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW     = $clog2(REFRESH_DIV);
    localparam int unsigned SH_W   = DIDX_W + 2;

    // Pin-level "off" values; XOR with these converts active-high to pin polarity.
    localparam logic [DIGITS-1:0] AN_OFF  = (SEG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [31:0]       shown_q,  shown_d;
    logic              upd_q,    upd_d;
    logic [PW-1:0]     presc_q,  presc_d;
    logic [DIDX_W-1:0] digit_q,  digit_d;
    logic [0:0]        state_q,  state_d;
    logic [SEG_W-1:0]  seg_q,    seg_d;
    logic [DIGITS-1:0] an_q,     an_d;
    logic              dp_q,     dp_d;

    logic [DW-1:0]     disp_c;
    logic [SH_W-1:0]   shift_c;
    logic [3:0]        nibble_c;
    logic [SEG_W-1:0]  glyph_c;
    logic              blank_c;
    logic              tc_c;

    // Glyph lookup for the nibble of the digit being driven.
    hex_to_seg7 u_hex (
        .nibble_i (nibble_c),
        .seg_c    (glyph_c)
    );

    // Capture, prescaler and digit index next-state.
    always_comb begin
        shown_d = bus.freeze ? shown_q : bus.outport_in;
        upd_d   = !bus.freeze && (bus.outport_in != shown_q);
        tc_c    = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d = tc_c ? '0 : presc_q + PW'(1);
        digit_d = digit_q;
        if (tc_c) begin
            digit_d = (digit_q == DIDX_W'(DIGITS - 1)) ? '0 : digit_q + DIDX_W'(1);
        end
    end

    // Digit data uses the value being captured this edge, giving 1-clock latency.
    always_comb begin
        disp_c   = shown_d[DW-1:0];
        shift_c  = {digit_q, 2'b00};
        nibble_c = 4'(disp_c >> shift_c);
        // Leading blank: this digit and every digit above it are zero.
        blank_c  = (LEADING_BLANK != 0) && (digit_q != '0) && ((disp_c >> shift_c) == '0);
    end

    // Scan FSM next-state and registered-output next values.
    always_comb begin
        state_d = state_q;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        case (state_q)
            ST_BLANK: begin
                // One all-off cycle per slot suppresses ghosting between digits.
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (tc_c) begin
                    state_d = ST_BLANK;
                end
                an_d  = (DIGITS'(1) << digit_q) ^ AN_OFF;
                seg_d = (blank_c ? '0 : glyph_c) ^ SEG_OFF;
                dp_d  = (bus.run && (digit_q == '0)) ^ DP_OFF;
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shown_q <= '0;
            upd_q   <= 1'b0;
            presc_q <= '0;
            digit_q <= '0;
            state_q <= ST_BLANK;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            dp_q    <= DP_OFF;
        end else begin
            shown_q <= shown_d;
            upd_q   <= upd_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.dp        = dp_q;
    assign bus.upd_pulse = upd_q;

endmodule

// File: doc/outport_seg7_driver.md
Name: outport_seg7_driver

Overview:
- Board-side consumer of the CPU output port: registers the 32-bit OUTPORTout value and time-multiplexes it as hexadecimal digits on a common-segment 7-segment display.
- Also flags each new port value and shows a CPU-run heartbeat on the decimal point.
- Sits beside mini_src_group_1 in the FPGA top level: OUTPORTout and run feed this block, and its outputs drive the display pins.

Parameters:
- DIGITS, 8, number of displayed hex digits; the block shows bits [4*DIGITS-1:0]; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot including the blank cycle; minimum 2.
- LEADING_BLANK, 1, when 1 the block suppresses leading zero digits.
- SEG_ACTIVE_LOW, 1, when 1 seg, dp and an are active-low at the pins.

Ports:
- clk  input  1  system clock, same clock as the CPU.
- reset  input  1  asynchronous, active-low reset.
- outport_in  input  32  CPU OUTPORTout value.
- run  input  1  CPU run flag.
- freeze  input  1  when 1, holds the displayed value and ignores outport_in.
- seg  output  7  segments a..g, seg[0]=a.
- dp  output  1  decimal point.
- an  output  DIGITS  digit enables; an[0] is the rightmost digit.
- upd_pulse  output  1  one-cycle strobe when a new value is captured.

Behaviour:
- Reset (reset=0), asynchronous:
  - shown=0, prescaler=0, digit_idx=0, state=BLANK.
  - All of an, seg and dp inactive at their pin polarity.
  - upd_pulse=0.
- Capture, every clk edge with freeze=0:
  - shown <= outport_in.
  - upd_pulse <= (outport_in != shown). The strobe is visible in the cycle after the change is sampled. Latency from an outport_in change to updated seg data is 1 clock.
- Capture with freeze=1: shown holds and upd_pulse=0. When freeze is released, a pending difference produces exactly one upd_pulse.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit_idx advances, wrapping DIGITS-1 -> 0.
- FSM, states BLANK and SHOW:
  - BLANK lasts exactly 1 cycle at prescaler==0. All an are inactive (anti-ghosting). Next state is SHOW.
  - SHOW covers prescaler 1..REFRESH_DIV-1. Only an[digit_idx] is active.
  - At terminal count the FSM goes to BLANK.
- Segment data:
  - Nibble = shown[4*digit_idx+3 : 4*digit_idx], mapped to standard hex glyphs 0-F. b and d are lowercase; the rest are uppercase.
- Leading blank (LEADING_BLANK=1):
  - Digit i>0 is blanked when all nibbles at index >=i are zero. While blanked, an stays active and seg is all-off.
  - Digit 0 is never blanked, so shown=0 displays a single "0".
- Decimal point:
  - Lit only on digit 0, and only when run=1.
  - The run input is sampled the same cycle it is used, with no registering.
- All outputs (seg, dp, an) are registered and change only on clk edges.
- Polarity inversion is applied at the output registers.
- A reset asserted mid-scan returns the block to the reset state immediately, regardless of prescaler phase.

Decomposition:
- Shared package io_pkg:
  - 16-entry hex-to-segment constant table, active-high form.
  - FSM state encoding: BLANK=1'b0, SHOW=1'b1.
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit lookup. This is the only sub-module.
- The prescaler, FSM and capture logic live in outport_seg7_driver.

Test Plan (REFRESH_DIV=4, DIGITS=8, SEG_ACTIVE_LOW=0 unless stated):
- Reset held low with outport_in=32'h12345678:
  - Expect an=0, seg=0, dp=0, upd_pulse=0.
  - After release, first edge is BLANK, then an=8'h01 with seg=glyph 8 for 3 cycles.
- Steady value 32'h12345678:
  - Over 32 cycles an cycles 01,02,...,80 and back to 01.
  - Each digit slot is preceded by one all-off cycle.
  - Digit 7 shows glyph 1.
- outport_in 0 -> 32'h000000A5 while scanning, LEADING_BLANK=1:
  - Exactly one upd_pulse.
  - Digits 2-7 show seg=0 with an still asserted.
  - Digit 1 shows A and digit 0 shows 5.
  - With value 0, only digit 0 shows 0.
- freeze=1, then outport_in changes to 32'hDEADBEEF:
  - Display and shown are unchanged and no upd_pulse occurs.
  - On freeze=0: one upd_pulse, then the digits show d,E,A,d,b,E,E,F.
- run toggles: dp=1 only while an=8'h01 and run=1, otherwise dp=0.
- SEG_ACTIVE_LOW=1 with a mid-scan reset pulse:
  - Outputs go to an=8'hFF, seg=7'h7F, dp=1 asynchronously.
  - Scan restarts at digit 0.
